conv_window_gen3x3_fp16: RTL and testbench
==========================================

Name: conv_window_gen3x3_fp16

Overview:
Streaming 3x3 sliding-window generator that produces the nine fp16 operands consumed by the 3x3 conv adder-tree datapath. Accepts one ifmap pixel per handshake in row-major raster order. Buffers two previous rows in line buffers and emits one 3x3 window for every fully interior position (valid convolution, no padding, stride 1). Sits between the ifmap fetch stream and the multiply/adder-tree stage.

Parameters:
IMG_W, 16, image width in pixels; legal range >= 3
IMG_H, 16, image height in rows; legal range >= 3
DW, 16, pixel width in bits (fp16 raw bits, never interpreted arithmetically)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  asynchronous, active-high reset
in_valid  input  1  in_data holds a valid pixel
in_ready  output  1  block can accept a pixel this cycle
in_data  input  DW  pixel, row-major order
out_valid  output  1  out_win holds a valid window
out_ready  input  1  downstream accepts window
out_win  output  9xDW  packed [8:0][DW-1:0]; index 3*dy+dx; dy=0 oldest row, dx=0 leftmost column; [8] = newest pixel
out_last  output  1  qualifies last window of a frame

Behaviour:
- Reset (async, active-high): col=0, row=0, out_valid=0, out_last=0, out_win=0, window regs=0. Line buffers are not reset; gating makes their contents irrelevant.
- in_ready = !out_valid || out_ready (combinational). Pixel accepted iff in_valid && in_ready.
- Two line buffers, each IMG_W x DW, indexed by col: lb1 = row-1, lb2 = row-2.
- On accept:
  - Window shifts left one column.
  - New right column = {lb2[col], lb1[col], in_data} for dy=0,1,2.
  - lb2[col] <= lb1[col]; lb1[col] <= in_data.
- Counters:
  - col increments on each accept.
  - col==IMG_W-1 wraps col to 0 and increments row.
  - col==IMG_W-1 && row==IMG_H-1 wraps both to 0 (frame end).
- Output register:
  - On an accept with row>=2 && col>=2, the next cycle has out_valid=1 and out_win = the updated window (latency 1 cycle from accept).
  - out_last=1 iff that accept was at row==IMG_H-1 && col==IMG_W-1.
  - An accept at row<2 or col<2 drives out_valid to 0 next cycle, unless the held window has not been consumed. By the in_ready rule, an accept cannot occur while an unconsumed window is held.
  - out_valid && !out_ready: out_win, out_last and out_valid hold stable and in_ready=0.
  - out_valid && out_ready with no new accept: out_valid clears next cycle.
  - Simultaneous consume and accept: the new window (if the position qualifies) replaces the old one with no bubble. Full throughput is one window per cycle.
- Windows per frame: (IMG_W-2)*(IMG_H-2), one per interior pixel in raster order.
- Row wrap: a window never mixes columns from two image rows, because col<2 is gated.
- Frame wrap: the next frame starts at row 0. Stale lb contents are masked because row<2 is gated.
- Reset mid-frame: partial frame discarded; the next accepted pixel is treated as pixel (0,0).
- No arithmetic; data passes bit-exact.

Test Plan:
- IMG_W=IMG_H=4, in_data=0..15, out_ready=1, in_valid=1 continuous -> exactly 4 windows.
  - 1st, one cycle after pixel 10 accepted: out_win[0..8] = {0,1,2,4,5,6,8,9,10}.
  - 2nd: {1,2,3,5,6,7,9,10,11}.
  - 3rd: {4,5,6,8,9,10,12,13,14}.
  - 4th: {5,6,7,9,10,11,13,14,15} with out_last=1; out_last=0 on the other three.
- Same stream, out_ready=0 for 5 cycles when the 1st window appears -> in_ready=0 and out_win stable at {0,1,2,4,5,6,8,9,10} for all 5 cycles. After release, the remaining 3 windows are bit-exact and none are lost or duplicated.
- Random in_valid bubbles (~50%) and random out_ready -> window sequence identical to the no-stall case; count = 4 per frame.
- Two back-to-back 4x4 frames, second frame values 100..115 -> no out_valid during the first 10 accepts of frame 2. First window of frame 2 = {100,101,102,104,105,106,108,109,110}.
- rst pulse asserted after pixel 7 of a frame, then a fresh frame 0..15 -> out_valid=0 and outputs 0 immediately on reset, independent of clk. Windows after reset match the first scenario exactly.
- IMG_W=16, IMG_H=16 default, 256 incrementing pixels -> 196 windows, exactly one out_last (on the final window). Window at row r, col c has out_win[8] = 16r+c.

Source files
------------

// File: rtl/conv_window_gen3x3_fp16.sv
// -----------------------------------------------------------------------------
// conv_window_gen3x3_fp16
//
// Streaming 3x3 sliding-window generator for the conv adder-tree datapath.
// Takes one fp16 pixel per handshake in row-major raster order. Two line
// buffers hold the previous two rows. One 3x3 window is emitted for every
// fully interior position (valid convolution, stride 1, no padding).
// Pixel bits pass through unchanged and are never interpreted as numbers.
//
// Parameters
//   IMG_W  image width in pixels  (>= 3)
//   IMG_H  image height in rows   (>= 3)
//   DW     pixel width in bits
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   in_valid   in_data holds a valid pixel
//   in_ready   block can accept a pixel this cycle
//   in_data    pixel, row-major order
//   out_valid  out_win holds a valid window
//   out_ready  downstream accepts the window
//   out_win    [8:0][DW-1:0], index 3*dy+dx, dy=0 oldest row, dx=0 leftmost,
//              [8] is the newest pixel
//   out_last   marks the last window of a frame
// -----------------------------------------------------------------------------
module conv_window_gen3x3_fp16 #(
    parameter int IMG_W = 16,
    parameter int IMG_H = 16,
    parameter int DW    = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DW-1:0]        in_data,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [8:0][DW-1:0]   out_win,
    output logic                 out_last
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    // Raster position of the next pixel to be accepted.
    logic [CW-1:0] col;
    logic [RW-1:0] row;

    // Line buffers: lb1 holds row-1, lb2 holds row-2, both indexed by column.
    // They are never reset; the row/col gating keeps stale data out of any
    // emitted window.
    logic [DW-1:0] lb1 [IMG_W];
    logic [DW-1:0] lb2 [IMG_W];

    // Working window (stage p0) and the registered output window (stage p1).
    logic [8:0][DW-1:0] win_p0;
    logic [8:0][DW-1:0] win_nxt;
    logic [8:0][DW-1:0] win_p1;
    logic               vld_p1;
    logic               last_p1;

    logic accept;
    logic col_end;
    logic frame_end;
    logic interior;

    // A new pixel may enter only when the output slot is empty or draining,
    // so a held window is never overwritten.
    assign in_ready  = !vld_p1 || out_ready;
    assign accept    = in_valid && in_ready;

    assign col_end   = (col == COL_LAST);
    assign frame_end = col_end && (row == ROW_LAST);
    // Columns 0/1 and rows 0/1 would pull in data from the previous row or
    // previous frame, so only positions with a full 3x3 neighbourhood count.
    assign interior  = (row >= ROW_TWO) && (col >= COL_TWO);

    // Window shifted left by one column with the new column entering at dx=2.
    always_comb begin
        win_nxt = win_p0;
        for (int dy = 0; dy < 3; dy++) begin
            win_nxt[3*dy + 0] = win_p0[3*dy + 1];
            win_nxt[3*dy + 1] = win_p0[3*dy + 2];
        end
        win_nxt[2] = lb2[col];
        win_nxt[5] = lb1[col];
        win_nxt[8] = in_data;
    end

    // ---- stage p0: raster counters and working window ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col    <= '0;
            row    <= '0;
            win_p0 <= '0;
        end else if (accept) begin
            win_p0 <= win_nxt;
            if (col_end) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + RW'(1);
            end else begin
                col <= col + CW'(1);
            end
        end
    end

    // Line buffer update: the column moves up one row on every accept.
    always_ff @(posedge clk) begin
        if (accept) begin
            lb2[col] <= lb1[col];
            lb1[col] <= in_data;
        end
    end

    // ---- stage p1: output register ----
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
            win_p1  <= '0;
        end else if (accept) begin
            // An accept implies the previous window was consumed (or absent),
            // so it is safe to replace or clear the slot here.
            vld_p1  <= interior;
            last_p1 <= interior && frame_end;
            if (interior) begin
                win_p1 <= win_nxt;
            end
        end else if (out_ready) begin
            vld_p1  <= 1'b0;
            last_p1 <= 1'b0;
        end
    end

    assign out_valid = vld_p1;
    assign out_win   = win_p1;
    assign out_last  = last_p1;

endmodule

// File: tb/tb_conv_window_gen3x3_fp16.sv
// -----------------------------------------------------------------------------
// tb_conv_window_gen3x3_fp16
//
// Bench for conv_window_gen3x3_fp16. Instance 0 is a 4x4 image, instance 1 the
// default 16x16. A raster model stores every accepted pixel in an image array
// and pushes the expected window for each interior position onto a queue;
// windows leaving the DUT are popped and compared.
// -----------------------------------------------------------------------------
module tb_conv_window_gen3x3_fp16;

    typedef struct packed {
        logic [8:0][15:0] win;
        logic             last;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             in_valid  [2];
    logic             in_ready  [2];
    logic [15:0]      in_data   [2];
    logic             out_valid [2];
    logic             out_ready [2];
    logic [8:0][15:0] out_win   [2];
    logic             out_last  [2];

    int n_tests = 0;
    int n_fail  = 0;
    int n_win   = 0;
    int n_last  = 0;

    exp_t        sbq [$];
    exp_t        e;
    logic [15:0] img [16][16];
    int          mr = 0;
    int          mc = 0;

    conv_window_gen3x3_fp16 #(.IMG_W(4), .IMG_H(4), .DW(16)) dut4 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid[0]),
        .in_ready  (in_ready[0]),
        .in_data   (in_data[0]),
        .out_valid (out_valid[0]),
        .out_ready (out_ready[0]),
        .out_win   (out_win[0]),
        .out_last  (out_last[0])
    );

    conv_window_gen3x3_fp16 #(.IMG_W(16), .IMG_H(16), .DW(16)) dut16 (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid[1]),
        .in_ready  (in_ready[1]),
        .in_data   (in_data[1]),
        .out_valid (out_valid[1]),
        .out_ready (out_ready[1]),
        .out_win   (out_win[1]),
        .out_last  (out_last[1])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [143:0] got, input logic [143:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Scoreboard and raster model, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            sbq.delete();
            mr = 0;
            mc = 0;
        end else begin
            for (int k = 0; k < 2; k++) begin
                int w;
                int h;
                w = (k == 0) ? 4 : 16;
                h = w;
                if (out_valid[k] && out_ready[k]) begin
                    check("win_pending", 144'(sbq.size() > 0), 144'(1));
                    if (sbq.size() > 0) begin
                        e = sbq.pop_front();
                        check("win", out_win[k], e.win);
                        check("last", 144'(out_last[k]), 144'(e.last));
                        n_win++;
                        if (out_last[k]) n_last++;
                    end
                end
                if (in_valid[k] && in_ready[k]) begin
                    img[mr][mc] = in_data[k];
                    if (mr >= 2 && mc >= 2) begin
                        for (int dy = 0; dy < 3; dy++)
                            for (int dx = 0; dx < 3; dx++)
                                e.win[3*dy + dx] = img[mr - 2 + dy][mc - 2 + dx];
                        e.last = (mr == h - 1) && (mc == w - 1);
                        sbq.push_back(e);
                    end
                    if (mc == w - 1) begin
                        mc = 0;
                        mr = (mr == h - 1) ? 0 : mr + 1;
                    end else begin
                        mc = mc + 1;
                    end
                end
            end
        end
    end

    // Drive pixels base+p0 .. base+p1 into instance k with random bubbles on
    // in_valid (bub %) and random back-pressure on out_ready (stl %).
    task automatic feed(input int k, input int base, input int p0, input int p1,
                        input int bub, input int stl);
        bit acc;
        int guard;
        for (int p = p0; p <= p1; p++) begin
            acc   = 1'b0;
            guard = 0;
            in_data[k] = 16'(base + p);
            while (!acc && guard < 1000) begin
                in_valid[k]  = ($urandom_range(99) >= bub);
                out_ready[k] = ($urandom_range(99) >= stl);
                @(negedge clk);
                acc = in_valid[k] && in_ready[k];
                @(posedge clk);
                #1;
                guard++;
            end
            if (!acc) check("accept_timeout", 144'(acc), 144'(1));
        end
    endtask

    task automatic drain(input int k);
        in_valid[k]  = 1'b0;
        out_ready[k] = 1'b1;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic expect_counts(input string tag, input int w0, input int l0,
                                 input int nw, input int nl);
        check({tag, "_windows"}, 144'(n_win - w0), 144'(nw));
        check({tag, "_lasts"}, 144'(n_last - l0), 144'(nl));
        check({tag, "_queue_empty"}, 144'(sbq.size()), 144'(0));
    endtask

    logic [8:0][15:0] first_w;
    int w0;
    int l0;

    initial begin
        for (int i = 0; i < 9; i++) first_w[i] = 16'((i / 3) * 4 + (i % 3));
        for (int k = 0; k < 2; k++) begin
            in_valid[k]  = 1'b0;
            in_data[k]   = '0;
            out_ready[k] = 1'b1;
        end
        rst = 1'b0;
        #1 rst = 1'b1;
        #2;
        check("rst_out_valid", 144'(out_valid[0]), 144'(0));
        check("rst_out_last", 144'(out_last[0]), 144'(0));
        check("rst_out_win", out_win[0], 144'(0));
        check("rst_out_win16", out_win[1], 144'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        check("rst_in_ready", 144'(in_ready[0]), 144'(1));

        // Continuous 4x4 frame, plus first-window latency.
        w0 = n_win; l0 = n_last;
        feed(0, 0, 0, 10, 0, 0);
        check("first_latency", 144'(out_valid[0]), 144'(1));
        check("first_win", out_win[0], first_w);
        feed(0, 0, 11, 15, 0, 0);
        drain(0);
        expect_counts("cont", w0, l0, 4, 1);

        // Output held for 5 cycles on the first window.
        w0 = n_win; l0 = n_last;
        feed(0, 0, 0, 10, 0, 0);
        out_ready[0] = 1'b0;
        in_valid[0]  = 1'b1;
        in_data[0]   = 16'd11;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_in_ready", 144'(in_ready[0]), 144'(0));
            check("stall_valid", 144'(out_valid[0]), 144'(1));
            check("stall_win", out_win[0], first_w);
            @(posedge clk);
            #1;
        end
        feed(0, 0, 11, 15, 0, 0);
        drain(0);
        expect_counts("stall", w0, l0, 4, 1);

        // Random bubbles and back-pressure over two frames.
        w0 = n_win; l0 = n_last;
        feed(0, 0, 0, 15, 50, 50);
        feed(0, 0, 0, 15, 50, 50);
        drain(0);
        expect_counts("random", w0, l0, 8, 2);

        // Back-to-back frames, second frame 100..115.
        w0 = n_win; l0 = n_last;
        feed(0, 0, 0, 15, 0, 0);
        feed(0, 100, 0, 15, 0, 0);
        drain(0);
        expect_counts("b2b", w0, l0, 8, 2);

        // Asynchronous reset while a window is held.
        feed(0, 0, 0, 10, 0, 0);
        in_valid[0]  = 1'b0;
        out_ready[0] = 1'b0;
        check("held_before_rst", 144'(out_valid[0]), 144'(1));
        #2 rst = 1'b1;
        #1;
        check("async_rst_valid", 144'(out_valid[0]), 144'(0));
        check("async_rst_win", out_win[0], 144'(0));
        check("async_rst_in_ready", 144'(in_ready[0]), 144'(1));
        @(posedge clk);
        #1 rst = 1'b0;
        out_ready[0] = 1'b1;

        // Reset after pixel 7, then a fresh frame.
        w0 = n_win; l0 = n_last;
        feed(0, 0, 0, 7, 0, 0);
        in_valid[0] = 1'b0;
        rst = 1'b1;
        #1;
        check("midframe_rst_valid", 144'(out_valid[0]), 144'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        feed(0, 0, 0, 15, 0, 0);
        drain(0);
        expect_counts("after_rst", w0, l0, 4, 1);

        // Default 16x16 frame.
        w0 = n_win; l0 = n_last;
        feed(1, 0, 0, 255, 0, 0);
        drain(1);
        expect_counts("img16", w0, l0, 196, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
